// File: rtl/xadc_multi_sampler.sv
// Round-robin XADC DRP reader with per-channel box-car averaging.
// Optional hysteresis threshold outputs are built when XADC_SAMPLER_THRESH_EN is defined.
module xadc_multi_sampler #(
    parameter int NUM_CH    = 2,
    parameter int AUX_FIRST = 6,
    parameter int AVG_LOG2  = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   eoc_in,
    output logic [6:0]             drp_daddr,
    output logic                   drp_den,
    output logic                   drp_dwe,
    output logic [15:0]            drp_di,
    input  logic                   drp_drdy,
    input  logic [15:0]            drp_do,
    output logic [12*NUM_CH-1:0]   sample_out,
    output logic [NUM_CH-1:0]      sample_valid,
    output logic                   busy,
    output logic                   err
`ifdef XADC_SAMPLER_THRESH_EN
    ,
    input  logic [11:0]            thresh_hi,
    input  logic [11:0]            thresh_lo,
    output logic [NUM_CH-1:0]      over
`endif
);

    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'((1 << AVG_LOG2) - 1);
    localparam logic [6:0]    BASE_ADDR = 7'(16 + AUX_FIRST);
    localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_ACC  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic                  pend_q, pend_d;
    logic                  err_q, err_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [11:0]           smp_q, smp_d;
    logic [AW-1:0]         acc_q [NUM_CH];
    logic [AW-1:0]         acc_d [NUM_CH];
    logic [CW-1:0]         cnt_q [NUM_CH];
    logic [CW-1:0]         cnt_d [NUM_CH];
    logic [12*NUM_CH-1:0]  sample_q, sample_d;
    logic [NUM_CH-1:0]     valid_q, valid_d;
    logic                  den_q, den_d;
    logic [6:0]            daddr_q, daddr_d;
    logic                  busy_q, busy_d;
`ifdef XADC_SAMPLER_THRESH_EN
    logic [NUM_CH-1:0]     over_q, over_d;
`endif

    logic [AW-1:0]         acc_sel_s;
    logic [CW-1:0]         cnt_sel_s;
    logic [AW-1:0]         sum_s;
    logic [11:0]           avg_s;
    logic                  unused_s;

    // The low nibble of the DRP word carries no conversion data.
    assign unused_s = ^drp_do[3:0];

    // Select the accumulator and count of the channel currently being served.
    always_comb begin
        acc_sel_s = {AW{1'b0}};
        cnt_sel_s = {CW{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (ptr_q == PW'(i)) begin
                acc_sel_s = acc_q[i];
                cnt_sel_s = cnt_q[i];
            end else begin
                acc_sel_s = acc_sel_s;
                cnt_sel_s = cnt_sel_s;
            end
        end
    end

    // Width 12+AVG_LOG2 holds 2^AVG_LOG2 full-scale samples without overflow.
    assign sum_s = acc_sel_s + AW'(smp_q);
    assign avg_s = sum_s[AVG_LOG2 +: 12];

    // Next-state and datapath update for the DRP read sequence.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        pend_d   = pend_q;
        err_d    = err_q;
        timer_d  = timer_q;
        smp_d    = smp_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        valid_d  = {NUM_CH{1'b0}};
        den_d    = 1'b0;
        daddr_d  = daddr_q;
`ifdef XADC_SAMPLER_THRESH_EN
        over_d   = over_q;
`endif

        // A conversion finishing mid-transaction is queued once; a second one is lost.
        if ((state_q != S_IDLE) && eoc_in) begin
            if (pend_q) begin
                err_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end else begin
            pend_d = pend_d;
        end

        case (state_q)
            S_IDLE: begin
                if (eoc_in || pend_q) begin
                    state_d = S_REQ;
                    pend_d  = 1'b0;
                    den_d   = 1'b1;
                    daddr_d = BASE_ADDR + 7'(ptr_q);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
                timer_d = {TW{1'b0}};
            end
            S_WAIT: begin
                if (drp_drdy) begin
                    smp_d   = drp_do[15:4];
                    state_d = S_ACC;
                end else if (timer_q >= TIMER_END) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_ACC: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ptr_q == PW'(i)) begin
                        if (cnt_sel_s == CNT_LAST) begin
                            sample_d[12*i +: 12] = avg_s;
                            valid_d[i]           = 1'b1;
                            acc_d[i]             = {AW{1'b0}};
                            cnt_d[i]             = {CW{1'b0}};
`ifdef XADC_SAMPLER_THRESH_EN
                            if (avg_s > thresh_hi) begin
                                over_d[i] = 1'b1;
                            end else if (avg_s < thresh_lo) begin
                                over_d[i] = 1'b0;
                            end else begin
                                over_d[i] = over_q[i];
                            end
`endif
                        end else begin
                            acc_d[i] = sum_s;
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end else begin
                        acc_d[i] = acc_d[i];
                    end
                end
                if (ptr_q == PW'(NUM_CH - 1)) begin
                    ptr_d = {PW{1'b0}};
                end else begin
                    ptr_d = ptr_q + PW'(1);
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; everything clears on reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            ptr_q    <= {PW{1'b0}};
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            timer_q  <= {TW{1'b0}};
            smp_q    <= 12'h000;
            sample_q <= {(12*NUM_CH){1'b0}};
            valid_q  <= {NUM_CH{1'b0}};
            den_q    <= 1'b0;
            daddr_q  <= BASE_ADDR;
            busy_q   <= 1'b0;
`ifdef XADC_SAMPLER_THRESH_EN
            over_q   <= {NUM_CH{1'b0}};
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= {AW{1'b0}};
                cnt_q[i] <= {CW{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
            smp_q    <= smp_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            den_q    <= den_d;
            daddr_q  <= daddr_d;
            busy_q   <= busy_d;
`ifdef XADC_SAMPLER_THRESH_EN
            over_q   <= over_d;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign drp_daddr    = daddr_q;
    assign drp_den      = den_q;
    assign drp_dwe      = 1'b0;
    assign drp_di       = 16'h0000;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign err          = err_q;
`ifdef XADC_SAMPLER_THRESH_EN
    assign over         = over_q;
`endif

endmodule

// File: tb/tb_xadc_multi_sampler.sv
// Directed bench: three sampler instances (no averaging, 4-sample, 64-sample) share one stimulus.
module tb_xadc_multi_sampler;

    localparam int NCH = 2;
    localparam int TO  = 16;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        eoc_in = 1'b0;
    logic        drp_drdy = 1'b0;
    logic [15:0] drp_do = 16'h0000;
    logic [11:0] thresh_hi = 12'h800;
    logic [11:0] thresh_lo = 12'h700;

    logic [6:0]        daddr_a, daddr_b, daddr_c;
    logic              den_a, den_b, den_c;
    logic              dwe_a, dwe_b, dwe_c;
    logic [15:0]       di_a, di_b, di_c;
    logic [12*NCH-1:0] sample_a, sample_b, sample_c;
    logic [NCH-1:0]    valid_a, valid_b, valid_c;
    logic              busy_a, busy_b, busy_c;
    logic              err_a, err_b, err_c;
`ifdef XADC_SAMPLER_THRESH_EN
    logic [NCH-1:0]    over_a, over_b, over_c;
`endif

    xadc_multi_sampler #(.NUM_CH(NCH), .AUX_FIRST(6), .AVG_LOG2(0), .TIMEOUT(TO)) u_dut_a (
        .CLK(CLK), .RST_N(RST_N), .eoc_in(eoc_in),
        .drp_daddr(daddr_a), .drp_den(den_a), .drp_dwe(dwe_a), .drp_di(di_a),
        .drp_drdy(drp_drdy), .drp_do(drp_do),
        .sample_out(sample_a), .sample_valid(valid_a), .busy(busy_a), .err(err_a)
`ifdef XADC_SAMPLER_THRESH_EN
        , .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .over(over_a)
`endif
    );

    xadc_multi_sampler #(.NUM_CH(NCH), .AUX_FIRST(6), .AVG_LOG2(2), .TIMEOUT(TO)) u_dut_b (
        .CLK(CLK), .RST_N(RST_N), .eoc_in(eoc_in),
        .drp_daddr(daddr_b), .drp_den(den_b), .drp_dwe(dwe_b), .drp_di(di_b),
        .drp_drdy(drp_drdy), .drp_do(drp_do),
        .sample_out(sample_b), .sample_valid(valid_b), .busy(busy_b), .err(err_b)
`ifdef XADC_SAMPLER_THRESH_EN
        , .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .over(over_b)
`endif
    );

    xadc_multi_sampler #(.NUM_CH(NCH), .AUX_FIRST(6), .AVG_LOG2(6), .TIMEOUT(TO)) u_dut_c (
        .CLK(CLK), .RST_N(RST_N), .eoc_in(eoc_in),
        .drp_daddr(daddr_c), .drp_den(den_c), .drp_dwe(dwe_c), .drp_di(di_c),
        .drp_drdy(drp_drdy), .drp_do(drp_do),
        .sample_out(sample_c), .sample_valid(valid_c), .busy(busy_c), .err(err_c)
`ifdef XADC_SAMPLER_THRESH_EN
        , .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .over(over_c)
`endif
    );

    initial begin
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int         n_vec = 0;
    int         n_err = 0;
    logic [6:0] addr_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_dut();
        RST_N = 1'b0;
        repeat (2) tick();
        RST_N = 1'b1;
        tick();
    endtask

    // Pulse eoc; returns in the cycle where den should be high.
    task automatic start_req();
        eoc_in = 1'b1;
        tick();
        eoc_in = 1'b0;
        addr_seen = daddr_a;
        chk("den_pulse", {31'd0, den_a}, 32'd1);
        chk("busy_rise", {31'd0, busy_a}, 32'd1);
    endtask

    // Answer lat cycles after den; returns when the result should be visible.
    task automatic finish(input logic [11:0] val, input int lat);
        repeat (lat) tick();
        drp_drdy = 1'b1;
        drp_do   = {val, 4'h0};
        tick();
        drp_drdy = 1'b0;
        drp_do   = 16'h0000;
        tick();
    endtask

    task automatic xact(input logic [11:0] val, input int lat);
        start_req();
        finish(val, lat);
    endtask

    initial begin
        logic [11:0] val;
        logic [1:0]  exp_v;

        reset_dut();
        chk("rst_sample", 32'(sample_a), 32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_err", {31'd0, err_a}, 32'd0);
        chk("rst_den", {31'd0, den_a}, 32'd0);
        chk("rst_addr", 32'(daddr_a), 32'h16);

        // No averaging: two channels, DRP answers three cycles after den
        xact(12'hABC, 3);
        chk("t1_addr0", 32'(addr_seen), 32'h16);
        chk("t1_valid0", 32'(valid_a), 32'h1);
        chk("t1_slice0", 32'(sample_a[11:0]), 32'hABC);
        chk("t1_busy_fall", {31'd0, busy_a}, 32'd0);
        chk("t1_avg2_nopulse", 32'(valid_b), 32'd0);
        tick();
        chk("t1_valid_once", 32'(valid_a), 32'd0);
        xact(12'h123, 3);
        chk("t1_addr1", 32'(addr_seen), 32'h17);
        chk("t1_valid1", 32'(valid_a), 32'h2);
        chk("t1_slice1", 32'(sample_a[23:12]), 32'h123);
        chk("t1_slice0_hold", 32'(sample_a[11:0]), 32'hABC);

        // Four-sample average, channels interleaved
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            val   = (i % 2 == 0) ? 12'(32'h100 + i / 2) : 12'(32'h200 + i / 2);
            exp_v = (i == 6) ? 2'b01 : ((i == 7) ? 2'b10 : 2'b00);
            xact(val, 2);
            chk("avg2_valid", 32'(valid_b), 32'(exp_v));
            chk("avg0_track", 32'(valid_a), (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        chk("avg2_slice0", 32'(sample_b[11:0]), 32'h101);
        chk("avg2_slice1", 32'(sample_b[23:12]), 32'h201);

        // 64-sample average of full scale
        reset_dut();
        for (int i = 0; i < 128; i++) begin
            exp_v = (i == 126) ? 2'b01 : ((i == 127) ? 2'b10 : 2'b00);
            xact(12'hFFF, 1);
            chk("avg6_valid", 32'(valid_c), 32'(exp_v));
        end
        chk("avg6_slice0", 32'(sample_c[11:0]), 32'hFFF);
        chk("avg6_slice1", 32'(sample_c[23:12]), 32'hFFF);
        chk("avg6_err", {31'd0, err_c}, 32'd0);

        // Two extra eoc during WAIT
        reset_dut();
        start_req();
        tick();
        eoc_in = 1'b1;
        tick();
        chk("pend_no_err", {31'd0, err_a}, 32'd0);
        tick();
        eoc_in = 1'b0;
        chk("pend_err", {31'd0, err_a}, 32'd1);
        drp_drdy = 1'b1;
        drp_do   = 16'h3C30;
        tick();
        drp_drdy = 1'b0;
        drp_do   = 16'h0000;
        tick();
        chk("pend_valid0", 32'(valid_a), 32'h1);
        chk("pend_slice0", 32'(sample_a[11:0]), 32'h3C3);
        tick();
        chk("pend_den", {31'd0, den_a}, 32'd1);
        chk("pend_addr", 32'(daddr_a), 32'h17);
        finish(12'h5A5, 3);
        chk("pend_valid1", 32'(valid_a), 32'h2);
        chk("pend_slice1", 32'(sample_a[23:12]), 32'h5A5);
        repeat (6) tick();
        chk("pend_single", {31'd0, busy_a}, 32'd0);
        xact(12'h111, 2);
        chk("pend_ptr_wrap", 32'(addr_seen), 32'h16);
        chk("pend_err_sticky", {31'd0, err_a}, 32'd1);

        // DRP never answers
        reset_dut();
        start_req();
        repeat (TO) tick();
        chk("to_err_early", {31'd0, err_a}, 32'd0);
        chk("to_busy_wait", {31'd0, busy_a}, 32'd1);
        tick();
        chk("to_err", {31'd0, err_a}, 32'd1);
        chk("to_idle", {31'd0, busy_a}, 32'd0);
        drp_drdy = 1'b1;
        drp_do   = 16'h7770;
        tick();
        drp_drdy = 1'b0;
        drp_do   = 16'h0000;
        repeat (2) tick();
        chk("to_late_drdy", 32'(valid_a), 32'd0);
        xact(12'h456, 2);
        chk("to_same_addr", 32'(addr_seen), 32'h16);
        chk("to_retry_valid", 32'(valid_a), 32'h1);
        chk("to_retry_slice", 32'(sample_a[11:0]), 32'h456);

        // Reset while waiting for the DRP
        start_req();
        tick();
        RST_N = 1'b0;
        #1;
        chk("mid_rst_sample", 32'(sample_a), 32'd0);
        chk("mid_rst_valid", 32'(valid_a), 32'd0);
        chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("mid_rst_err", {31'd0, err_a}, 32'd0);
        chk("mid_rst_den", {31'd0, den_a}, 32'd0);
        chk("mid_rst_addr", 32'(daddr_a), 32'h16);
        tick();
        RST_N = 1'b1;
        tick();
        drp_drdy = 1'b1;
        drp_do   = 16'hFFF0;
        tick();
        drp_drdy = 1'b0;
        drp_do   = 16'h0000;
        repeat (2) tick();
        chk("late_drdy_valid", 32'(valid_a), 32'd0);
        chk("late_drdy_sample", 32'(sample_a), 32'd0);
        chk("late_drdy_busy", {31'd0, busy_a}, 32'd0);

`ifdef XADC_SAMPLER_THRESH_EN
        reset_dut();
        chk("thr_rst", 32'(over_a), 32'd0);
        xact(12'h810, 2);
        chk("thr_above", {31'd0, over_a[0]}, 32'd1);
        xact(12'h000, 2);
        chk("thr_ch1_low", {31'd0, over_a[1]}, 32'd0);
        xact(12'h750, 2);
        chk("thr_hold", {31'd0, over_a[0]}, 32'd1);
        xact(12'h000, 2);
        xact(12'h6FF, 2);
        chk("thr_below", {31'd0, over_a[0]}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/xadc_multi_sampler.md
# xadc_multi_sampler

Parametrised XADC front end for the station system. It drives the XADC DRP port itself, steps round-robin through NUM_CH auxiliary channels on each end-of-conversion, and box-car averages 2^AVG_LOG2 samples per channel. It publishes one averaged 12-bit reading per channel with a valid strobe. It sits between the XADC wizard instance and the temperature/display logic, and supersedes the fixed single-channel VAUX6 read.

## Interface
- NUM_CH, 2, number of aux channels sampled (1..8)
- AUX_FIRST, 6, first aux index; channel i reads DRP address 7'h10 + AUX_FIRST + i
- AVG_LOG2, 4, log2 of samples averaged per output (0..6; 0 = no averaging)
- TIMEOUT, 255, max cycles waited for drp_drdy before abort
- CLK  in  1  100 MHz system clock, all logic rising-edge
- RST_N  in  1  reset, asynchronous assert, active-low
- eoc_in  in  1  XADC eoc_out, one-cycle pulse
- drp_daddr  out  7  DRP address
- drp_den  out  1  DRP enable, one-cycle pulse
- drp_dwe  out  1  tied 0 (read-only)
- drp_di  out  16  tied 0
- drp_drdy  in  1  DRP data ready
- drp_do  in  16  DRP read data; result in [15:4]
- sample_out  out  12*NUM_CH  averaged reading, channel i in bits [12i+11:12i]
- sample_valid  out  NUM_CH  one-cycle pulse when channel i's slice updates
- busy  out  1  high outside IDLE
- err  out  1  sticky: overrun or DRP timeout seen; cleared only by reset

## Operation
- FSM states: IDLE, REQ, WAIT, ACC.
- IDLE: on eoc_in or pend=1, go to REQ and clear pend.
- REQ: drp_den=1 for exactly one cycle, drp_daddr = 7'h10+AUX_FIRST+ptr; go to WAIT.
- WAIT: on drp_drdy, latch drp_do[15:4] into smp and go to ACC. If the timer reaches TIMEOUT first, set err, leave acc/cnt/ptr unchanged, go to IDLE.
- ACC: sum = acc[ptr] + smp, width 12+AVG_LOG2, never overflows.
  - If cnt[ptr] == 2^AVG_LOG2-1: slice ptr <= sum >> AVG_LOG2 (truncate), pulse sample_valid[ptr], acc[ptr] <= 0, cnt[ptr] <= 0.
  - Else: acc[ptr] <= sum, cnt[ptr] +1.
  - Then ptr <= (ptr == NUM_CH-1) ? 0 : ptr+1; go to IDLE.
- eoc_in outside IDLE: set pend (one deep). eoc_in while pend=1 and not in IDLE: set err; the extra eoc is dropped.
- eoc_in in IDLE with pend=1: one transaction only.
- drp_drdy outside WAIT: ignored.
- drp_daddr holds its last value outside REQ. Reset value is 7'h10+AUX_FIRST.
- Reset mid-transaction: FSM to IDLE. acc, cnt, ptr, pend, err, sample_out, sample_valid, drp_den all go to 0. A late drdy after reset is ignored.

## Timing
- eoc_in at cycle t (IDLE) -> drp_den high at t+1.
- drp_drdy at cycle d -> FSM in ACC at d+1. sample_out slice and sample_valid are registered, visible at d+2.
- Minimum transaction: 4 cycles plus DRP latency.
- busy rises the cycle after eoc_in and falls on return to IDLE.
- All outputs are registered.

## Configuration
- XADC_SAMPLER_THRESH_EN defined:
  - Adds inputs thresh_hi[11:0], thresh_lo[11:0] and output over[NUM_CH-1:0], reset 0.
  - On each sample_valid[i]: over[i] sets if the new value > thresh_hi, clears if < thresh_lo, else holds (hysteresis).
- Not defined: those ports and that logic are absent.

## Test plan
- NUM_CH=2, AVG_LOG2=0, drdy 3 cycles after den, do=16'hABC0 then 16'h1230 -> slice0=12'hABC, then slice1=12'h123, with addresses 7'h16 then 7'h17.
- AVG_LOG2=2, channel 0 fed 12'h100, 12'h101, 12'h102, 12'h103 -> one sample_valid[0] after the 4th, value 12'h101; no pulse on earlier samples.
- AVG_LOG2=6, 64 samples of 12'hFFF -> output 12'hFFF, no overflow.
- Two extra eoc_in during WAIT -> err=1, exactly one pending transaction runs, ptr advances by 2 total.
- drdy withheld -> err=1 after TIMEOUT cycles, FSM returns to IDLE, and the next eoc rereads the same channel address.
- RST_N low during WAIT, late drdy after release -> all outputs 0, no sample_valid. With XADC_SAMPLER_THRESH_EN, thresh_hi=12'h800, thresh_lo=12'h700, samples 12'h810 then 12'h750 then 12'h6FF -> over = 1, 1, 0.
